inst_rom_arbiter: RTL and testbench

//  Shares the single combinational instruction ROM between two requesters: port 0 (IF-stage

---
 rtl/inst_rom_arbiter_if.sv | 15 +
 rtl/inst_rom_arbiter.sv | 55 +++++
 tb/tb_inst_rom_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/inst_rom_arbiter_if.sv
// inst_rom_arbiter_if: one requester's read request and response-slot handshake
interface inst_rom_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              rerr;
    logic              rready;
    modport master (output req, addr, rready, input gnt, rvalid, rdata, rerr);
    modport slave  (input req, addr, rready, output gnt, rvalid, rdata, rerr);
endinterface

// File: rtl/inst_rom_arbiter.sv
// inst_rom_arbiter: round-robin sharing of one combinational instruction ROM between two read
// ports, each with a one-entry registered response slot.
module inst_rom_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 131071
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst,
    inst_rom_arbiter_if.slave p0,
    inst_rom_arbiter_if.slave p1
);
    logic              rr, elig0, elig1, win1, any, bad;
    logic [ADDR_W-1:0] a, word;
    // A port may be granted only when its slot is empty or being drained this cycle.
    always_comb begin
        elig0 = p0.req & (~p0.rvalid | p0.rready);
        elig1 = p1.req & (~p1.rvalid | p1.rready);
        win1  = elig1 & (~elig0 | rr);
        any   = ~rst & (elig0 | elig1);
        a     = win1 ? p1.addr : p0.addr;
        word  = a >> 2;
        bad   = (a[1:0] != 2'b0) | (word >= ADDR_W'(MEM_WORDS));
    end
    assign p0.gnt   = any & ~win1;
    assign p1.gnt   = any & win1;
    assign rom_ce   = any & ~bad;
    assign rom_addr = rom_ce ? a : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr        <= 1'b0;
            p0.rvalid <= 1'b0;
            p0.rdata  <= '0;
            p0.rerr   <= 1'b0;
            p1.rvalid <= 1'b0;
            p1.rdata  <= '0;
            p1.rerr   <= 1'b0;
        end else begin
            if (any) rr <= ~win1;
            if (p0.gnt) begin
                p0.rvalid <= 1'b1;
                p0.rdata  <= bad ? '0 : rom_inst;
                p0.rerr   <= bad;
            end else if (p0.rready) p0.rvalid <= 1'b0;
            if (p1.gnt) begin
                p1.rvalid <= 1'b1;
                p1.rdata  <= bad ? '0 : rom_inst;
                p1.rerr   <= bad;
            end else if (p1.rready) p1.rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_inst_rom_arbiter.sv
// tb_inst_rom_arbiter: directed and random checks of the two-port ROM arbiter against a
// slot-level reference model.
module tb_inst_rom_arbiter;
    localparam int MW = 131071;
    logic        clk = 1'b0, rst = 1'b1;
    logic        rom_ce;
    logic [31:0] rom_addr, rom_inst;
    logic        req [2];
    logic [31:0] addr [2];
    logic        rready [2];
    logic        mv [2], me [2];
    logic [31:0] md [2];
    int          mrr;
    logic        gl [2];
    int          n_chk = 0, n_fail = 0;

    inst_rom_arbiter_if #(.ADDR_W(32), .DATA_W(32)) pi0 ();
    inst_rom_arbiter_if #(.ADDR_W(32), .DATA_W(32)) pi1 ();
    assign pi0.req = req[0];
    assign pi0.addr = addr[0];
    assign pi0.rready = rready[0];
    assign pi1.req = req[1];
    assign pi1.addr = addr[1];
    assign pi1.rready = rready[1];

    inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(MW)) dut (
        .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .p0(pi0), .p1(pi1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] romf(input logic [31:0] w);
        return w * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction
    always_comb rom_inst = rom_ce ? romf(rom_addr >> 2) : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_slots(input string tag);
        chk({tag, " p0_rvalid"}, 32'(pi0.rvalid), 32'(mv[0]));
        chk({tag, " p1_rvalid"}, 32'(pi1.rvalid), 32'(mv[1]));
        if (mv[0]) begin
            chk({tag, " p0_rdata"}, pi0.rdata, md[0]);
            chk({tag, " p0_rerr"}, 32'(pi0.rerr), 32'(me[0]));
        end
        if (mv[1]) begin
            chk({tag, " p1_rdata"}, pi1.rdata, md[1]);
            chk({tag, " p1_rerr"}, 32'(pi1.rerr), 32'(me[1]));
        end
    endtask

    // Called at a falling edge with inputs already applied; checks and advances one cycle.
    task automatic step(input string tag);
        logic e [2];
        logic any, bad;
        int w;
        logic [31:0] a;
        #1;
        for (int p = 0; p < 2; p++) e[p] = req[p] && (!mv[p] || rready[p]);
        any = e[0] || e[1];
        w = (e[0] && e[1]) ? mrr : (e[1] ? 1 : 0);
        a = addr[w];
        bad = (a % 4 != 0) || ((a / 4) >= MW);
        chk_slots(tag);
        chk({tag, " p0_gnt"}, 32'(pi0.gnt), 32'(any && w == 0));
        chk({tag, " p1_gnt"}, 32'(pi1.gnt), 32'(any && w == 1));
        chk({tag, " rom_ce"}, 32'(rom_ce), 32'(any && !bad));
        chk({tag, " rom_addr"}, rom_addr, (any && !bad) ? a : 32'h0);
        @(posedge clk);
        for (int p = 0; p < 2; p++) begin
            gl[p] = any && w == p;
            if (gl[p]) begin
                mv[p] = 1'b1;
                md[p] = bad ? 32'h0 : romf(a / 4);
                me[p] = bad;
            end else if (mv[p] && rready[p]) mv[p] = 1'b0;
        end
        if (any) mrr = 1 - w;
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            mv[p] = 1'b0;
            md[p] = 32'h0;
            me[p] = 1'b0;
            gl[p] = 1'b0;
        end
        mrr = 0;
    endtask

    initial begin
        model_reset();
        req[0] = 1'b1; addr[0] = 32'h10; rready[0] = 1'b1;
        req[1] = 1'b0; addr[1] = 32'h0;  rready[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst p0_gnt", 32'(pi0.gnt), 32'h0);
        chk("rst rom_ce", 32'(rom_ce), 32'h0);
        chk("rst rom_addr", rom_addr, 32'h0);
        chk("rst p0_rvalid", 32'(pi0.rvalid), 32'h0);
        chk("rst p1_rvalid", 32'(pi1.rvalid), 32'h0);
        chk("rst p0_rdata", pi0.rdata, 32'h0);
        chk("rst p1_rdata", pi1.rdata, 32'h0);
        chk("rst p0_rerr", 32'(pi0.rerr), 32'h0);
        chk("rst p1_rerr", 32'(pi1.rerr), 32'h0);
        rst = 1'b0;
        step("release");
        // single good read of word 2
        addr[0] = 32'h8;
        step("addr8");
        req[0] = 1'b0;
        step("addr8 resp");
        // both requesting with free slots alternate
        req[0] = 1'b1; req[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            addr[0] = 32'(i) * 4;
            addr[1] = 32'h100 + 32'(i) * 4;
            step("alt");
        end
        // p1 slot stalls: p1 gets one grant then p0 every cycle
        rready[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            addr[0] = 32'h200 + 32'(i) * 4;
            step("p1 stall");
        end
        rready[1] = 1'b1;
        addr[1] = 32'h300;
        step("p1 drain");
        step("p1 drain next");
        // misaligned and out-of-range requests
        req[1] = 1'b0;
        addr[0] = 32'h6;
        step("misaligned");
        addr[0] = MW * 4;
        step("out of range");
        addr[0] = (MW - 1) * 4;
        step("last word");
        addr[0] = 32'hFFFF_FFFC;
        step("top addr");
        req[0] = 1'b0;
        step("idle");
        // asynchronous reset with a stalled p1 response
        req[1] = 1'b1; addr[1] = 32'h44; rready[1] = 1'b0;
        step("p1 fill");
        req[1] = 1'b0; req[0] = 1'b1; addr[0] = 32'h20;
        step("p1 held");
        #2 rst = 1'b1;
        #1;
        chk("async p1_rvalid", 32'(pi1.rvalid), 32'h0);
        chk("async p0_rvalid", 32'(pi0.rvalid), 32'h0);
        chk("async p0_gnt", 32'(pi0.gnt), 32'h0);
        chk("async rom_ce", 32'(rom_ce), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        req[0] = 1'b1; req[1] = 1'b1; rready[0] = 1'b1; rready[1] = 1'b1;
        addr[0] = 32'h30; addr[1] = 32'h34;
        step("post rst tie");
        step("post rst tie2");
        // random traffic obeying the hold-until-grant rule
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(req[p] && !gl[p])) begin
                    req[p] = ($urandom % 4) != 0;
                    case ($urandom_range(0, 7))
                        0: addr[p] = $urandom;
                        1: addr[p] = (MW + $urandom_range(0, 64)) * 4;
                        default: addr[p] = $urandom_range(0, MW - 1) * 4;
                    endcase
                end
                rready[p] = ($urandom % 3) != 0;
            end
            step("random");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
